// File: rtl/spi_fpu_regfile_ctrl.sv
// SPI byte-stream command decoder owning a register file and sequencing an external FPU.
// Compute sequencing runs alongside command decode, so the link can be queried while busy.
module spi_fpu_regfile_ctrl #(
  parameter int NUM_REGS   = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  active,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  fpu_in_valid,
  input  logic                  fpu_in_ready,
  output logic [1:0]            fpu_op,
  output logic [DATA_WIDTH-1:0] fpu_a,
  output logic [DATA_WIDTH-1:0] fpu_b,
  input  logic [DATA_WIDTH-1:0] fpu_result,
  input  logic                  fpu_result_valid,
  output logic                  busy
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IW    = $clog2(NUM_REGS);
  localparam logic [3:0] LAST = 4'(BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_REGID, S_WDATA, S_RDATA, S_STATUS, S_OPERANDS, S_DRAIN
  } state_t;
  typedef enum logic [1:0] {C_IDLE, C_ISSUE, C_WAIT} cstate_t;

  state_t  r_state, w_next;
  cstate_t r_cstate, w_cnext;

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [7:0]            r_stage [BYTES];
  logic [3:0]            r_cnt;
  logic [IW-1:0]         r_dst, r_srca, r_srcb, r_cdst;
  logic                  r_is_read, r_err, r_done;
  logic [1:0]            r_pend_op, r_op;
  logic [DATA_WIDTH-1:0] r_a, r_b;

  logic                  w_wr_en, w_launch, w_pop, w_set_err, w_result_wr;
  logic [DATA_WIDTH-1:0] w_wvalue, w_rword;
  logic [7:0]            w_rbyte;

  assign busy         = (r_cstate != C_IDLE);
  assign fpu_in_valid = (r_cstate == C_ISSUE);
  assign fpu_op       = r_op;
  assign fpu_a        = r_a;
  assign fpu_b        = r_b;
  assign w_rword      = r_regs[r_dst];

  // Final write value: the byte arriving this cycle completes the staged word.
  always_comb begin
    w_wvalue = '0;
    w_rbyte  = '0;
    for (int unsigned i = 0; i < BYTES; i++) begin
      w_wvalue[i*8 +: 8] = (r_cnt == i[3:0]) ? rx_data : r_stage[i];
      if (r_cnt == i[3:0]) w_rbyte = w_rword[i*8 +: 8];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cstate <= C_IDLE;
    end else begin
      r_state  <= w_next;
      r_cstate <= w_cnext;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_wr_en   = 1'b0;
    w_launch  = 1'b0;
    w_pop     = 1'b0;
    w_set_err = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = '0;
    case (r_state)
      S_IDLE: if (active) w_next = S_CMD;
      S_CMD: if (rx_valid) begin
        case (rx_data[3:0])
          4'd0, 4'd1: begin
            if (busy) begin
              w_set_err = 1'b1;
              w_next    = S_DRAIN;
            end else begin
              w_next = rx_data[0] ? S_OPERANDS : S_REGID;
            end
          end
          4'd2:    w_next = S_REGID;
          4'd3:    w_next = S_STATUS;
          default: begin
            w_set_err = 1'b1;
            w_next    = S_DRAIN;
          end
        endcase
      end
      S_REGID: if (rx_valid) w_next = r_is_read ? S_RDATA : S_WDATA;
      S_WDATA: if (rx_valid && r_cnt == LAST) begin
        w_wr_en = 1'b1;
        w_next  = S_DRAIN;
      end
      S_RDATA: begin
        tx_valid = 1'b1;
        tx_data  = w_rbyte;
        if (tx_ready && r_cnt == LAST) w_next = S_DRAIN;
      end
      S_STATUS: begin
        tx_valid = 1'b1;
        tx_data  = {5'b0, r_done, r_err, busy};
        if (tx_ready) begin
          w_pop  = 1'b1;
          w_next = S_DRAIN;
        end
      end
      S_OPERANDS: if (rx_valid && r_cnt == 4'd2) begin
        w_launch = 1'b1;
        w_next   = S_DRAIN;
      end
      S_DRAIN: ;
      default: w_next = S_IDLE;
    endcase
    // Losing chip select aborts any partial command without side effects.
    if (!active && r_state != S_IDLE) begin
      w_next    = S_IDLE;
      w_wr_en   = 1'b0;
      w_launch  = 1'b0;
      w_pop     = 1'b0;
      w_set_err = 1'b0;
    end
  end

  always_comb begin
    w_cnext     = r_cstate;
    w_result_wr = 1'b0;
    case (r_cstate)
      C_IDLE:  if (w_launch) w_cnext = C_ISSUE;
      C_ISSUE: if (fpu_in_ready) w_cnext = C_WAIT;
      C_WAIT: if (fpu_result_valid) begin
        w_result_wr = 1'b1;
        w_cnext     = C_IDLE;
      end
      default: w_cnext = C_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      for (int unsigned i = 0; i < BYTES; i++) r_stage[i] <= '0;
      r_cnt     <= '0;
      r_dst     <= '0;
      r_srca    <= '0;
      r_srcb    <= '0;
      r_cdst    <= '0;
      r_is_read <= 1'b0;
      r_pend_op <= '0;
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_err     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        S_CMD: if (rx_valid) begin
          r_is_read <= (rx_data[3:0] == 4'd2);
          r_pend_op <= rx_data[5:4];
          r_cnt     <= '0;
        end
        S_REGID: if (rx_valid) begin
          r_dst <= rx_data[IW-1:0];
          r_cnt <= '0;
        end
        S_WDATA: if (rx_valid) begin
          for (int unsigned i = 0; i < BYTES; i++)
            if (r_cnt == i[3:0]) r_stage[i] <= rx_data;
          r_cnt <= r_cnt + 4'd1;
        end
        S_RDATA: if (tx_ready) r_cnt <= r_cnt + 4'd1;
        S_OPERANDS: if (rx_valid) begin
          if (r_cnt == 4'd0) r_srca <= rx_data[IW-1:0];
          if (r_cnt == 4'd1) r_srcb <= rx_data[IW-1:0];
          r_cnt <= r_cnt + 4'd1;
        end
        default: ;
      endcase
      if (w_launch) begin
        r_a    <= r_regs[r_srca];
        r_b    <= r_regs[r_srcb];
        r_cdst <= rx_data[IW-1:0];
        r_op   <= r_pend_op;
      end
      if (w_wr_en) r_regs[r_dst] <= w_wvalue;
      if (w_result_wr) r_regs[r_cdst] <= fpu_result;
      if (w_set_err) r_err <= 1'b1;
      else if (w_pop) r_err <= 1'b0;
      if (w_result_wr) r_done <= 1'b1;
      else if (w_pop) r_done <= 1'b0;
    end
  end
endmodule

// File: tb/tb_spi_fpu_regfile_ctrl.sv
// Transaction-level model of the register file, flags and FPU handshake, checked against the DUT every cycle.
module tb_spi_fpu_regfile_ctrl;
  localparam int NR = 8;
  localparam int DW = 32;
  localparam int NB = DW / 8;

  logic          clock = 1'b0;
  logic          reset, active, rx_valid, tx_ready, fpu_in_ready, fpu_result_valid;
  logic [7:0]    rx_data, tx_data;
  logic          tx_valid, fpu_in_valid, busy;
  logic [1:0]    fpu_op;
  logic [DW-1:0] fpu_a, fpu_b, fpu_result;

  spi_fpu_regfile_ctrl #(.NUM_REGS(NR), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset), .active(active),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .fpu_in_valid(fpu_in_valid), .fpu_in_ready(fpu_in_ready), .fpu_op(fpu_op),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_result(fpu_result),
    .fpu_result_valid(fpu_result_valid), .busy(busy)
  );

  initial forever #5 clock = ~clock;

  int vectors = 0;
  int errors  = 0;

  logic [DW-1:0] m_regs [NR];
  bit            m_busy, m_err, m_done, m_issue, m_tx_on;
  logic [1:0]    m_op;
  logic [DW-1:0] m_a, m_b;
  int            m_cdst;
  bit            chk_en = 1'b0;
  bit            edge_busy;
  int            ready_delay = 0, res_delay = 0;
  logic [DW-1:0] fpu_ret = '0;
  int            st = 0, scnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_busy = 0; m_err = 0; m_done = 0; m_issue = 0; m_tx_on = 0;
    m_op = '0; m_a = '0; m_b = '0; m_cdst = 0;
  endtask

  // Per-cycle comparison against the model
  initial forever begin
    @(negedge clock);
    if (chk_en) begin
      chk("busy", 64'(busy), 64'(m_busy));
      chk("fpu_in_valid", 64'(fpu_in_valid), 64'(m_issue));
      if (m_issue) begin
        chk("fpu_op", 64'(fpu_op), 64'(m_op));
        chk("fpu_a", 64'(fpu_a), 64'(m_a));
        chk("fpu_b", 64'(fpu_b), 64'(m_b));
      end
      if (!m_tx_on) begin
        chk("tx_valid_idle", 64'(tx_valid), 64'(0));
        chk("tx_data_idle", 64'(tx_data), 64'(0));
      end
    end
  end

  // FPU stand-in: delayed accept, delayed result, then model update
  initial begin
    fpu_in_ready = 0; fpu_result_valid = 0; fpu_result = '0;
    forever begin
      @(posedge clock); #1;
      fpu_in_ready = 0; fpu_result_valid = 0;
      if (reset) st = 0;
      else case (st)
        0: if (fpu_in_valid) begin scnt = ready_delay; st = 1; end
        1: if (scnt == 0) begin fpu_in_ready = 1; scnt = res_delay; st = 2; end
           else scnt--;
        2: begin
          m_issue = 0;
          if (scnt == 0) begin fpu_result = fpu_ret; fpu_result_valid = 1; st = 3; end
          else scnt--;
        end
        default: begin
          m_regs[m_cdst] = fpu_ret; m_busy = 0; m_done = 1;
          fpu_result = DW'($urandom); st = 0;
        end
      endcase
    end
  end

  task automatic tick(); @(posedge clock); #1; endtask
  task automatic gap(); repeat ($urandom_range(0, 2)) tick(); endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_valid = 1;
    @(posedge clock);
    edge_busy = m_busy;
    #1;
    rx_valid = 0; rx_data = 8'($urandom);
  endtask

  task automatic begin_txn(); active = 1; tick(); gap(); endtask
  task automatic end_txn(); active = 0; tick(); m_tx_on = 0; tick(); tick(); endtask

  task automatic do_reset();
    reset = 1; active = 0; rx_valid = 0; tx_ready = 0;
    tick(); clear_model(); tick();
    reset = 0; tick();
  endtask

  task automatic do_write(input logic [7:0] idx, input logic [DW-1:0] val, input int nb);
    bit rej;
    begin_txn();
    send_byte({4'($urandom), 4'h0});
    rej = edge_busy;
    if (rej) m_err = 1;
    gap(); send_byte(idx);
    for (int i = 0; i < nb; i++) begin gap(); send_byte(val[i*8 +: 8]); end
    if (!rej && nb == NB) m_regs[int'(idx) % NR] = val;
    end_txn();
  endtask

  task automatic do_read(input logic [7:0] idx, output logic [DW-1:0] got);
    int r;
    r = int'(idx) % NR;
    got = '0;
    begin_txn();
    send_byte({4'($urandom), 4'h2}); gap(); send_byte(idx);
    m_tx_on = 1;
    for (int i = 0; i < NB; i++) begin
      gap();
      @(negedge clock);
      chk("rd_tx_valid", 64'(tx_valid), 64'(1));
      chk("rd_byte", 64'(tx_data), 64'(m_regs[r][i*8 +: 8]));
      got[i*8 +: 8] = tx_data;
      tx_ready = 1;
      @(posedge clock); #1;
      tx_ready = 0;
    end
    m_tx_on = 0;
    end_txn();
  endtask

  task automatic do_status(output logic [7:0] got);
    bit rv;
    begin_txn();
    send_byte({4'($urandom), 4'h3});
    m_tx_on = 1;
    gap();
    @(negedge clock);
    chk("st_tx_valid", 64'(tx_valid), 64'(1));
    chk("st_byte", 64'(tx_data), 64'({5'b0, m_done, m_err, m_busy}));
    got = tx_data;
    tx_ready = 1;
    @(posedge clock);
    rv = fpu_result_valid;
    #1;
    tx_ready = 0; m_err = 0;
    if (!rv) m_done = 0;
    m_tx_on = 0;
    end_txn();
  endtask

  task automatic do_compute(input logic [1:0] op, input logic [7:0] sa, input logic [7:0] sb,
                            input logic [7:0] d, input logic [DW-1:0] ret, input int rdly, input int resdly);
    bit rej;
    begin_txn();
    send_byte({2'($urandom), op, 4'h1});
    rej = edge_busy;
    if (rej) m_err = 1;
    gap(); send_byte(sa); gap(); send_byte(sb); gap();
    if (!rej) begin ready_delay = rdly; res_delay = resdly; fpu_ret = ret; end
    send_byte(d);
    if (!rej) begin
      m_issue = 1; m_busy = 1; m_op = op;
      m_a = m_regs[int'(sa) % NR]; m_b = m_regs[int'(sb) % NR]; m_cdst = int'(d) % NR;
    end
    end_txn();
  endtask

  task automatic do_bad(input logic [7:0] cmd);
    begin_txn();
    send_byte(cmd);
    m_err = 1;
    repeat (3) begin gap(); send_byte(8'($urandom)); end
    end_txn();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && m_busy; i++) tick();
    chk("compute_finished", 64'(busy), 64'(0));
  endtask

  logic [DW-1:0] v;
  logic [7:0]    s;

  initial begin
    reset = 1; active = 0; rx_valid = 0; rx_data = '0; tx_ready = 0;
    tick(); tick();
    clear_model();
    reset = 0; tick();
    chk_en = 1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_tx_valid", 64'(tx_valid), 64'(0));
    chk("rst_tx_data", 64'(tx_data), 64'(0));
    chk("rst_fpu_in_valid", 64'(fpu_in_valid), 64'(0));

    do_write(8'h05, 32'h3F800000, NB);
    do_read(8'h05, v);
    chk("t1_reg5", 64'(v), 64'(32'h3F800000));
    for (int i = 0; i < NR; i++) if (i != 5) do_read(8'(i), v);

    do_write(8'h02, 32'hCAFEF00D, 2);
    do_read(8'h02, v);
    chk("t2_atomic", 64'(v), 64'(0));
    do_write(8'h0A, 32'h12345678, NB);
    do_read(8'h02, v);
    chk("t2_wrap", 64'(v), 64'(32'h12345678));

    do_write(8'h01, 32'h3F800000, NB);
    do_write(8'h02, 32'h40000000, NB);
    do_compute(2'd2, 8'd1, 8'd2, 8'd3, 32'h40000000, 3, 2);
    chk("t3_model_a", 64'(m_a), 64'(32'h3F800000));
    chk("t3_fpu_a", 64'(fpu_a), 64'(32'h3F800000));
    chk("t3_fpu_b", 64'(fpu_b), 64'(32'h40000000));
    chk("t3_fpu_op", 64'(fpu_op), 64'(2));
    wait_idle();
    do_read(8'h03, v);
    chk("t3_reg3", 64'(v), 64'(32'h40000000));
    do_status(s); chk("t3_status1", 64'(s), 64'(8'h04));
    do_status(s); chk("t3_status2", 64'(s), 64'(8'h00));

    do_compute(2'd0, 8'd3, 8'd1, 8'd6, 32'h40400000, 0, 20);
    chk("t4_busy_link_down", 64'(busy), 64'(1));
    wait_idle();
    do_read(8'h06, v);
    chk("t4_reg6", 64'(v), 64'(32'h40400000));
    do_status(s); chk("t4_status", 64'(s), 64'(8'h04));

    do_compute(2'd1, 8'd1, 8'd2, 8'd7, 32'hDEADBEEF, 1, 80);
    do_write(8'h01, 32'h11111111, NB);
    do_status(s); chk("t5_status", 64'(s), 64'(8'h03));
    do_read(8'h01, v);
    chk("t5_reg1", 64'(v), 64'(32'h3F800000));
    wait_idle();
    do_status(s); chk("t5_status_done", 64'(s), 64'(8'h04));

    do_bad(8'h07);
    do_status(s); chk("t6_status", 64'(s), 64'(8'h02));
    do_compute(2'd3, 8'd1, 8'd2, 8'd4, 32'h0BADF00D, 0, 300);
    repeat (8) tick();
    do_reset();
    chk("t6_busy", 64'(busy), 64'(0));
    for (int i = 0; i < NR; i++) begin
      do_read(8'(i), v);
      chk("t6_reg_zero", 64'(v), 64'(0));
    end

    for (int n = 0; n < 160; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: do_write(8'($urandom), DW'($urandom),
                          ($urandom_range(0, 9) == 0) ? $urandom_range(0, NB - 1) : NB);
        3, 4:    do_read(8'($urandom), v);
        5:       do_status(s);
        6, 7:    do_compute(2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                            DW'($urandom), $urandom_range(0, 4), $urandom_range(0, 15));
        8:       do_bad({4'($urandom), 4'($urandom_range(4, 15))});
        default: repeat ($urandom_range(1, 10)) tick();
      endcase
    end
    wait_idle();
    for (int i = 0; i < NR; i++) do_read(8'(i), v);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/spi_fpu_regfile_ctrl.md
Name: spi_fpu_regfile_ctrl

Overview:
- Parametrised second-generation SPI-to-FPU command controller.
- Sits between the byte-level SPI receiver (rx/tx byte handshake plus active flag) and an external floating-point execution unit.
- Owns a NUM_REGS-deep register file and decodes write, read, compute and status commands.
- Additions over the first generation:
  - configurable width and depth
  - 4-way operation select
  - atomic (staged) register writes
  - compute that survives chip-select deassertion
  - a status byte with sticky flags

Parameters:
NUM_REGS, 8, register count; power of two, 2..16; register index = low log2(NUM_REGS) bits of index byte.
DATA_WIDTH, 32, register width; multiple of 8, 8..64; BYTES = DATA_WIDTH/8.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
active  in  1  SPI transaction in progress (chip select asserted, synchronised)
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe, rx_data valid
tx_data  out  8  byte to shift out next
tx_valid  out  1  tx_data is meaningful
tx_ready  in  1  one-cycle strobe, SPI consumed tx_data
fpu_in_valid  out  1  operands/op presented
fpu_in_ready  in  1  FPU accepts operands
fpu_op  out  2  0 add, 1 sub, 2 mul, 3 min
fpu_a  out  DATA_WIDTH  operand A
fpu_b  out  DATA_WIDTH  operand B
fpu_result  in  DATA_WIDTH  result
fpu_result_valid  in  1  one-cycle strobe, result valid
busy  out  1  compute outstanding

Behaviour:

Reset:
- State IDLE.
- All registers 0.
- busy, err and done flags 0.
- tx_valid 0, tx_data 0, fpu_in_valid 0.

Transaction start/end:
- IDLE -> CMD when active=1.
- active=0 in any state except ISSUE/WAIT -> IDLE next cycle.

Command byte (in CMD, on rx_valid):
- cmd[3:0]=0 WRITE -> REGID
- cmd[3:0]=1 COMPUTE -> OPERANDS; op=cmd[5:4] latched
- cmd[3:0]=2 READ -> REGID
- cmd[3:0]=3 STATUS -> STATUS
- other values: set err, -> DRAIN

WRITE/COMPUTE while busy:
- set err, -> DRAIN; command discarded.

REGID:
- Next rx byte latches dst index -> WDATA (WRITE) or RDATA (READ).
- Byte counter = 0.

WDATA:
- BYTES bytes, little-endian, shifted into a staging register.
- Destination written in the cycle the last byte arrives, then -> DRAIN.
- active dropping early: no register modified (atomic write).

RDATA:
- tx_valid=1; tx_data = register[dst] byte[counter].
- Each tx_ready increments counter; after BYTES pops -> DRAIN.
- Register value sampled per byte; no snapshot.

STATUS:
- tx_valid=1; tx_data = {5'b0, done, err, busy}.
- On tx_ready: err and done cleared (unless re-set in the same cycle: set wins), -> DRAIN.

OPERANDS:
- Three rx bytes: srcA, srcB, dst.
- After dst: busy=1, -> ISSUE.

ISSUE:
- fpu_in_valid=1 with fpu_a=reg[srcA], fpu_b=reg[srcB], fpu_op latched.
- Operand values are captured into holding registers on entry to ISSUE, so writes are blocked anyway.
- Held until fpu_in_ready=1 -> WAIT.

WAIT:
- On fpu_result_valid: reg[dst] <= fpu_result, busy=0, done=1.
- Next state: IDLE if active=0, else DRAIN.

ISSUE/WAIT with active=0:
- Stays in state; compute completes independently of the SPI link.
- Does not enter CMD until done.

DRAIN:
- Ignores rx bytes; tx_valid=0, tx_data=0 until active=0.

Ordering and aliasing:
- srcA=srcB=dst permitted.
- Result written to dst only.

Simultaneous events:
- reset dominates everything.
- fpu_result_valid in the same cycle as a STATUS pop: done ends at 1.
- In WAIT, unexpected rx bytes are ignored.

tx_data:
- Combinational from state/counter.
- 0 whenever tx_valid=0.

Test Plan:
1. Reset, then WRITE 0x00, idx 0x05, bytes 00 00 80 3F; READ idx 5 -> tx bytes 00 00 80 3F; all other registers read 0.
2. WRITE idx 2 with only 2 data bytes, then active dropped; READ idx 2 -> 00 00 00 00 (atomic write); WRITE idx 0x0A with NUM_REGS=8 -> lands in register 2.
3. reg1=0x3F800000, reg2=0x40000000; COMPUTE cmd 0x21 (mul), src 1, src 2, dst 3 -> fpu_op=2, fpu_a=0x3F800000, fpu_b=0x40000000; fpu_in_ready delayed 3 cycles keeps fpu_in_valid high; result 0x40000000 writes reg3; STATUS -> 0x04, then 0x00.
4. COMPUTE issued, active dropped before result; result arrives 20 cycles later -> reg[dst] updated, busy falls; next STATUS -> 0x04.
5. While busy: WRITE -> discarded, STATUS reads 0x03; READ of a non-dst register returns its data correctly.
6. Command 0x07 -> err set, remaining bytes ignored; STATUS -> 0x02; reset asserted mid-WAIT -> state IDLE, busy 0, all registers 0.
